// File: rtl/multdiv_seq_pkg.sv
// Shared constants, state encoding and decode helper
// for the multiply/divide sequencer.
package multdiv_seq_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam logic [4:0]  REG_RSTATUS = 5'd30;
  localparam logic [31:0] RSTATUS_MUL = 32'd4;
  localparam logic [31:0] RSTATUS_DIV = 32'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_WB    = 2'b11
  } state_e;

  typedef enum logic {
    KIND_MUL = 1'b0,
    KIND_DIV = 1'b1
  } kind_e;

  function automatic logic is_md_op(
    input logic [4:0] op,
    input logic [4:0] alu
  );
    return (op == OP_RTYPE) &&
           ((alu == ALU_MUL) || (alu == ALU_DIV));
  endfunction

endpackage

// File: rtl/md_timeout_counter.sv
// Saturating WAIT-cycle counter for the multdiv watchdog.
// Ports: clk_i, rst_i (sync, high), clear_i, enable_i,
//   expired_o (count has reached TIMEOUT-1).
module md_timeout_counter #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned W = $clog2(TIMEOUT) + 1;
  localparam logic [W-1:0] CMAX = {W{1'b1}};
  localparam logic [W-1:0] CEXP = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != CMAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CEXP);

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequences R-type mul/div through the shared multdiv unit:
// stalls the pipe, pulses start, waits, then writes back.
// Ports: clock, reset (sync, high); insn_valid/opcode/aluop/rd
//   from decode; ctrl_mult/ctrl_div start pulses;
//   md_result/md_exception/md_ready from multdiv;
//   stall, busy; wb_en/wb_reg/wb_data register-file write.
// Build option: MULTDIV_TIMEOUT_EN adds a WAIT watchdog.
module multdiv_sequencer
  import multdiv_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        insn_valid,
  input  logic [4:0]  opcode,
  input  logic [4:0]  aluop,
  input  logic [4:0]  rd,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic        stall,
  output logic        busy,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data
);

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] res_q, res_d;
  logic        exc_q, exc_d;
  logic        is_md;
  logic        timeout;

  assign is_md = insn_valid & is_md_op(opcode, aluop);

`ifdef MULTDIV_TIMEOUT_EN
  md_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk_i     (clock),
    .rst_i     (reset),
    .clear_i   (state_q == S_ISSUE),
    .enable_i  (state_q == S_WAIT),
    .expired_o (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    rd_d    = rd_q;
    res_d   = res_q;
    exc_d   = exc_q;
    unique case (state_q)
      S_IDLE: begin
        if (is_md) begin
          rd_d    = rd;
          kind_d  = (aluop == ALU_DIV) ?
                    KIND_DIV : KIND_MUL;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // a real result beats the watchdog
        if (md_ready) begin
          res_d   = md_result;
          exc_d   = md_exception;
          state_d = S_WB;
        end else if (timeout) begin
          exc_d   = 1'b1;
          state_d = S_WB;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      kind_q  <= KIND_MUL;
      rd_q    <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
    end
  end

  // reset gates the control outputs so they are
  // quiet even before the first edge settles state
  assign stall = ~reset &
                 (((state_q == S_IDLE) & is_md) |
                  (state_q == S_ISSUE) |
                  (state_q == S_WAIT));

  assign busy = ~reset & (state_q != S_IDLE);

  assign ctrl_mult = ~reset & (state_q == S_ISSUE) &
                     (kind_q == KIND_MUL);
  assign ctrl_div  = ~reset & (state_q == S_ISSUE) &
                     (kind_q == KIND_DIV);

  // x0 is never written; exceptions always land
  // in rstatus
  assign wb_en = ~reset & (state_q == S_WB) &
                 (exc_q | (rd_q != 5'd0));

  assign wb_reg  = exc_q ? REG_RSTATUS : rd_q;
  assign wb_data = exc_q ?
                   ((kind_q == KIND_DIV) ?
                    RSTATUS_DIV : RSTATUS_MUL) :
                   res_q;

endmodule

// File: doc/multdiv_sequencer.md
# multdiv_sequencer

Multi-cycle sequencer for the processor's shared multiply/divide unit. It detects R-type `mul` and `div` instructions from the decoded opcode and ALU-op fields, and holds the PC and pipeline with a stall. It issues a one-cycle start pulse to the multdiv unit, then waits for that unit's ready. It then performs the register writeback itself: result to `rd`, or the exception status code to `$r30` (rstatus).

## Interface
Parameters:
- TIMEOUT, 40, maximum WAIT cycles before the operation is aborted (only used with the watchdog compiled in)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- insn_valid  in  1  decoded instruction present this cycle
- opcode  in  5  instruction opcode field
- aluop  in  5  instruction ALU-op field
- rd  in  5  destination register field
- ctrl_mult  out  1  one-cycle start pulse, multiply
- ctrl_div  out  1  one-cycle start pulse, divide
- md_result  in  32  multdiv result
- md_exception  in  1  multdiv exception (overflow / divide-by-zero)
- md_ready  in  1  multdiv result valid
- stall  out  1  hold PC and decode stage
- busy  out  1  sequencer not IDLE
- wb_en  out  1  register-file write enable (sequencer port)
- wb_reg  out  5  write register
- wb_data  out  32  write data

## Operation
- Detect: is_md = insn_valid & opcode==00000 & (aluop==00110 mul | aluop==00111 div). Only evaluated in IDLE.
- States: IDLE, ISSUE, WAIT, WB (2-bit encoding).
- IDLE:
  - stall = is_md (combinational).
  - On is_md, latch rd and kind (mul/div), then go to ISSUE.
- ISSUE:
  - Exactly one of ctrl_mult/ctrl_div = 1, per latched kind.
  - Clear the wait counter, then go to WAIT.
  - md_ready in this cycle is ignored.
- WAIT:
  - Counter increments each cycle.
  - On md_ready: capture md_result and md_exception, then go to WB.
  - Watchdog (macro on): if counter == TIMEOUT-1 and md_ready is low, force exception=1 and go to WB.
  - md_ready arriving in the timeout cycle wins; the real result is captured.
- WB:
  - No exception: wb_en = (rd != 0), wb_reg = rd, wb_data = captured result.
  - Exception: wb_en = 1, wb_reg = 30, wb_data = 4 (mul) or 5 (div).
  - Always go to IDLE next.
- stall = 1 in ISSUE and WAIT; stall = 0 in WB, so the PC advances at the end of WB.
- A new is_md is not detected in WB; back-to-back mul/div restarts detection in the following IDLE cycle.
- Non-mul/div instructions pass with stall = 0 and wb_en = 0.

## Timing
- Reset values:
  - State IDLE; counter 0; latched rd/kind/result/exception 0.
  - While reset is high, stall, busy, ctrl_mult, ctrl_div and wb_en are all 0 regardless of inputs.
- Reset in any state returns to IDLE on the next edge and drops any pending writeback.
- Latency, with detect at cycle T0:
  - ISSUE at T1, first WAIT at T2.
  - md_ready at WAIT cycle Tk gives WB at Tk+1.
  - Minimum: WB at T3, stall high for T0–T2 (3 cycles).
- Worst case with watchdog: TIMEOUT WAIT cycles, WB at T2+TIMEOUT.
- Counter width is clog2(TIMEOUT)+1 bits and saturates; it never wraps.
- All outputs except stall are decoded from registered state and registered data; stall is combinational from state and is_md.

## Configuration
- MULTDIV_TIMEOUT_EN:
  - Defined: watchdog counter and the forced-exception path are compiled in; TIMEOUT applies.
  - Undefined: no counter; WAIT exits only on md_ready, and TIMEOUT is unused.

## Structure
- Shared package/include `multdiv_seq_pkg`:
  - Opcode constant OP_RTYPE = 00000.
  - ALU-op constants ALU_MUL = 00110, ALU_DIV = 00111.
  - State encodings.
  - REG_RSTATUS = 30, RSTATUS_MUL = 4, RSTATUS_DIV = 5.
- Sub-module `md_timeout_counter`:
  - Ports: clear, enable, saturating count, `expired` flag.
  - Instantiated only under MULTDIV_TIMEOUT_EN.

## Test plan
- mul, rd=5, md_ready 3 cycles after ctrl_mult with md_result=0x0000002A -> ctrl_mult for one cycle; stall high T0–T4; wb_en=1, wb_reg=5, wb_data=0x2A at T5.
- div with md_exception=1 on ready -> wb_reg=30, wb_data=5, wb_en=1; same with mul -> wb_data=4.
- mul with rd=0, no exception -> full stall sequence; wb_en stays 0 in WB.
- Watchdog (macro on, TIMEOUT=4), md_ready never asserted -> WB at T6 with wb_reg=30, wb_data=4; macro off -> remains in WAIT with stall high indefinitely.
- Reset asserted during WAIT, then md_ready pulsed -> back to IDLE; no wb_en and no start pulse; stall=0 afterwards.
- Back-to-back mul then div, plus an add with insn_valid=1 -> two separate ISSUE pulses, one per instruction; the add produces stall=0 and wb_en=0.
